// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : fifo_pkg
//  Purpose  : Shared constants and gray/binary helpers for the async FIFO
//             read- and write-side pointer blocks.
//  Revision : 1.0  initial release
// ============================================================================
package fifo_pkg;

  localparam int FIFO_ADDRSIZE = 4;
  localparam int PTRW          = FIFO_ADDRSIZE + 1;
  localparam int DEPTH         = 1 << FIFO_ADDRSIZE;

  // Helpers work on a wide container; any narrower pointer is zero-extended
  // into it, and zero upper bits convert to zero upper bits, so the low
  // bits of the result are exact for every width up to MAXW.
  localparam int MAXW = 32;

  function automatic logic [MAXW-1:0] bin2gray(input logic [MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAXW-1:0] gray2bin(input logic [MAXW-1:0] g);
    logic [MAXW-1:0] b;
    b[MAXW-1] = g[MAXW-1];
    for (int i = MAXW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rptr_empty_lvl_if.sv
`default_nettype none
// ============================================================================
//  Interface : rptr_empty_lvl_if
//  Purpose   : Read-side request/status bundle of the async FIFO.
//  Revision  : 1.0  initial release
// ============================================================================
interface rptr_empty_lvl_if import fifo_pkg::*; #(
  parameter int ADDRSIZE = FIFO_ADDRSIZE
);

  logic                rinc;
  logic [ADDRSIZE:0]   rq2_wptr;
  logic [ADDRSIZE:0]   ae_thresh;
  logic                runderflow_clr;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;
  logic                rempty;
  logic                ralmost_empty;
  logic [ADDRSIZE:0]   rlevel;
  logic                runderflow;

  // Reader / environment side
  modport master (
    output rinc, rq2_wptr, ae_thresh, runderflow_clr,
    input  raddr, rptr, rempty, ralmost_empty, rlevel, runderflow
  );

  // Pointer block side
  modport slave (
    input  rinc, rq2_wptr, ae_thresh, runderflow_clr,
    output raddr, rptr, rempty, ralmost_empty, rlevel, runderflow
  );

endinterface
`default_nettype wire

// File: rtl/rptr_empty_lvl_gray2bin.sv
`default_nettype none
// ============================================================================
//  Module   : gray2bin_conv
//  Purpose  : Combinational gray-to-binary converter, W bits wide.
//  Revision : 1.0  initial release
// ============================================================================
module gray2bin_conv #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Binary bit i is the parity of all gray bits from the MSB down to i.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end

endmodule
`default_nettype wire

// File: rtl/rptr_empty_lvl.sv
`default_nettype none
// ============================================================================
//  Module   : rptr_empty_lvl
//  Purpose  : Async FIFO read-side pointer, empty flag, fill level,
//             almost-empty flag and sticky underflow error (rclk domain).
//  Revision : 1.0  initial release
// ============================================================================
module rptr_empty_lvl import fifo_pkg::*; #(
  parameter int ADDRSIZE = FIFO_ADDRSIZE,
  parameter bit LVL_REG  = 1'b1
) (
  input  logic             rclk,
  input  logic             rrst_n,
  rptr_empty_lvl_if.slave  bus
);

  localparam int PW = ADDRSIZE + 1;

  logic [PW-1:0] rbin;
  logic [PW-1:0] rbinnext;
  logic [PW-1:0] rgraynext;
  logic [PW-1:0] rptr_q;
  logic [PW-1:0] wbin;
  logic          rempty_q;
  logic          runderflow_q;
  logic          rd_ok;

  gray2bin_conv #(.W(PW)) u_wptr_g2b (
    .gray (bus.rq2_wptr),
    .bin  (wbin)
  );

  // A read only advances the pointer when data is actually present.
  assign rd_ok     = bus.rinc & ~rempty_q;
  assign rbinnext  = rbin + PW'(rd_ok);
  assign rgraynext = (rbinnext >> 1) ^ rbinnext;

  // Binary/gray pointer pair and registered empty flag.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin     <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
    end else begin
      rbin     <= rbinnext;
      rptr_q   <= rgraynext;
      rempty_q <= (rgraynext == bus.rq2_wptr);
    end
  end

  if (LVL_REG) begin : g_lvl_reg
    logic [PW-1:0] lvl_next;
    logic [PW-1:0] rlevel_q;
    logic          rae_q;

    assign lvl_next = wbin - rbinnext;

    // Level is taken from the post-read pointer so it stays aligned with rempty.
    always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
        rlevel_q <= '0;
        rae_q    <= 1'b1;
      end else begin
        rlevel_q <= lvl_next;
        rae_q    <= (lvl_next <= bus.ae_thresh);
      end
    end

    assign bus.rlevel        = rlevel_q;
    assign bus.ralmost_empty = rae_q;
  end else begin : g_lvl_comb
    logic [PW-1:0] lvl_cur;

    assign lvl_cur           = wbin - rbin;
    assign bus.rlevel        = lvl_cur;
    assign bus.ralmost_empty = (lvl_cur <= bus.ae_thresh);
  end

  // Sticky underflow: a new violation outranks a clear in the same cycle.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      runderflow_q <= 1'b0;
    end else if (bus.rinc && rempty_q) begin
      runderflow_q <= 1'b1;
    end else if (bus.runderflow_clr) begin
      runderflow_q <= 1'b0;
    end
  end

  assign bus.raddr      = rbin[ADDRSIZE-1:0];
  assign bus.rptr       = rptr_q;
  assign bus.rempty     = rempty_q;
  assign bus.runderflow = runderflow_q;

endmodule
`default_nettype wire

// File: tb/tb_rptr_empty_lvl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rptr_empty_lvl
//  Purpose  : Self-checking bench for rptr_empty_lvl (ADDRSIZE=4, LVL_REG=1).
//  Revision : 1.0  initial release
// ============================================================================
module tb_rptr_empty_lvl;
  import fifo_pkg::*;

  typedef struct {
    logic [4:0] rptr;
    logic [3:0] raddr;
    logic       rempty;
    logic       ae;
    logic [4:0] lvl;
    logic       uf;
  } exp_t;

  logic rclk = 1'b0;
  logic rrst_n;

  rptr_empty_lvl_if #(.ADDRSIZE(4)) bus ();

  rptr_empty_lvl #(.ADDRSIZE(4), .LVL_REG(1'b1)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .bus    (bus.slave)
  );

  always #5 rclk = ~rclk;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  // Reference model state
  logic [4:0] m_rbin;
  logic       m_rempty;
  logic       m_uf;

  // Structural properties that must hold at every sample point.
  always @(negedge rclk) begin
    if (rrst_n) begin
      assert (bus.rlevel <= 5'd16) else $error("rlevel %0d above depth", bus.rlevel);
      assert (!bus.rempty || bus.rlevel == 5'd0) else $error("empty with rlevel %0d", bus.rlevel);
    end
  end

  function automatic logic [4:0] gray5(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_rbin   = '0;
    m_rempty = 1'b1;
    m_uf     = 1'b0;
  endtask

  // Drive one cycle of stimulus, predict the post-edge outputs, queue them.
  task automatic step(input logic inc, input logic clr);
    exp_t        e;
    logic [31:0] t;
    logic [4:0]  wb;
    logic [4:0]  nb;
    @(negedge rclk);
    bus.rinc           = inc;
    bus.runderflow_clr = clr;
    t  = gray2bin(32'(bus.rq2_wptr));
    wb = t[4:0];
    nb = m_rbin + ((inc && !m_rempty) ? 5'd1 : 5'd0);
    if (inc && m_rempty) m_uf = 1'b1;
    else if (clr)        m_uf = 1'b0;
    m_rempty = (nb == wb);
    m_rbin   = nb;
    e.rptr   = gray5(nb);
    e.raddr  = nb[3:0];
    e.rempty = m_rempty;
    e.lvl    = wb - nb;
    e.ae     = (e.lvl <= bus.ae_thresh);
    e.uf     = m_uf;
    sb.push_back(e);
    @(posedge rclk);
    #1;
    bus.rinc           = 1'b0;
    bus.runderflow_clr = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge rclk);
    rrst_n = 1'b0;
    #2;
    rrst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rrst_n = 1'b0;
    bus.rinc = 1'b0; bus.runderflow_clr = 1'b0;
    bus.rq2_wptr = 5'd0; bus.ae_thresh = 5'd2;
    model_reset();
    #23;
    n_vec++; if (bus.rempty !== 1'b1) begin n_err++; $display("FAIL reset_rempty got %b want 1", bus.rempty); end
    n_vec++; if (bus.ralmost_empty !== 1'b1) begin n_err++; $display("FAIL reset_ae got %b want 1", bus.ralmost_empty); end
    n_vec++; if (bus.rlevel !== 5'd0) begin n_err++; $display("FAIL reset_lvl got %0d want 0", bus.rlevel); end
    n_vec++; if (bus.rptr !== 5'd0) begin n_err++; $display("FAIL reset_rptr got %b want 0", bus.rptr); end
    n_vec++; if (bus.raddr !== 4'd0) begin n_err++; $display("FAIL reset_raddr got %0d want 0", bus.raddr); end
    n_vec++; if (bus.runderflow !== 1'b0) begin n_err++; $display("FAIL reset_uf got %b want 0", bus.runderflow); end
    @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  task automatic test_fill_drain();
    exp_t e;
    bus.rq2_wptr = 5'b00010;
    step(1'b0, 1'b0);
    e = sb.pop_front();
    n_vec++; if (bus.rempty !== e.rempty) begin n_err++; $display("FAIL fill_rempty got %b want %b", bus.rempty, e.rempty); end
    n_vec++; if (bus.rlevel !== e.lvl) begin n_err++; $display("FAIL fill_lvl got %0d want %0d", bus.rlevel, e.lvl); end
    n_vec++; if (bus.ralmost_empty !== e.ae) begin n_err++; $display("FAIL fill_ae got %b want %b", bus.ralmost_empty, e.ae); end
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, 1'b0);
      e = sb.pop_front();
      n_vec++; if (bus.raddr !== e.raddr) begin n_err++; $display("FAIL drain_raddr[%0d] got %0d want %0d", k, bus.raddr, e.raddr); end
      n_vec++; if (bus.rlevel !== e.lvl) begin n_err++; $display("FAIL drain_lvl[%0d] got %0d want %0d", k, bus.rlevel, e.lvl); end
      n_vec++; if (bus.ralmost_empty !== e.ae) begin n_err++; $display("FAIL drain_ae[%0d] got %b want %b", k, bus.ralmost_empty, e.ae); end
      n_vec++; if (bus.rempty !== e.rempty) begin n_err++; $display("FAIL drain_rempty[%0d] got %b want %b", k, bus.rempty, e.rempty); end
      n_vec++; if (bus.runderflow !== e.uf) begin n_err++; $display("FAIL drain_uf[%0d] got %b want %b", k, bus.runderflow, e.uf); end
    end
  endtask

  task automatic test_wrap();
    exp_t       e;
    logic [4:0] prev;
    bus.rq2_wptr = gray5(m_rbin + 5'd1);
    step(1'b0, 1'b0);
    e = sb.pop_front();
    n_vec++; if (bus.rempty !== e.rempty) begin n_err++; $display("FAIL wrap_prime_rempty got %b want %b", bus.rempty, e.rempty); end
    for (int k = 0; k < 40; k++) begin
      prev = bus.rptr;
      bus.rq2_wptr = gray5(m_rbin + 5'd2);
      step(1'b1, 1'b0);
      e = sb.pop_front();
      n_vec++; if (bus.rptr !== e.rptr) begin n_err++; $display("FAIL wrap_rptr[%0d] got %b want %b", k, bus.rptr, e.rptr); end
      n_vec++; if (bus.raddr !== e.raddr) begin n_err++; $display("FAIL wrap_raddr[%0d] got %0d want %0d", k, bus.raddr, e.raddr); end
      n_vec++; if ($countones(bus.rptr ^ prev) != 1) begin n_err++; $display("FAIL wrap_hamming[%0d] got %0d want 1", k, $countones(bus.rptr ^ prev)); end
      n_vec++; if (bus.rempty !== 1'b0) begin n_err++; $display("FAIL wrap_rempty[%0d] got %b want 0", k, bus.rempty); end
    end
    n_vec++; if (bus.runderflow !== 1'b0) begin n_err++; $display("FAIL wrap_uf got %b want 0", bus.runderflow); end
  endtask

  task automatic test_full();
    exp_t e;
    pulse_reset();
    bus.rq2_wptr  = 5'b11000;
    bus.ae_thresh = 5'd2;
    step(1'b0, 1'b0);
    e = sb.pop_front();
    n_vec++; if (bus.rlevel !== e.lvl) begin n_err++; $display("FAIL full_lvl got %0d want %0d", bus.rlevel, e.lvl); end
    n_vec++; if (bus.rempty !== e.rempty) begin n_err++; $display("FAIL full_rempty got %b want %b", bus.rempty, e.rempty); end
    n_vec++; if (bus.ralmost_empty !== e.ae) begin n_err++; $display("FAIL full_ae got %b want %b", bus.ralmost_empty, e.ae); end
    bus.ae_thresh = 5'd16;
    step(1'b0, 1'b0);
    e = sb.pop_front();
    n_vec++; if (bus.ralmost_empty !== e.ae) begin n_err++; $display("FAIL full_ae16 got %b want %b", bus.ralmost_empty, e.ae); end
    n_vec++; if (bus.rlevel !== e.lvl) begin n_err++; $display("FAIL full_lvl16 got %0d want %0d", bus.rlevel, e.lvl); end
    bus.ae_thresh = 5'd2;
  endtask

  task automatic test_underflow();
    exp_t       e;
    logic [1:0] inc_v [4] = '{2'b10, 2'b00, 2'b11, 2'b01};
    pulse_reset();
    bus.rq2_wptr = 5'd0;
    for (int k = 0; k < 4; k++) begin
      step(inc_v[k][1], inc_v[k][0]);
      e = sb.pop_front();
      n_vec++; if (bus.runderflow !== e.uf) begin n_err++; $display("FAIL uf_flag[%0d] got %b want %b", k, bus.runderflow, e.uf); end
      n_vec++; if (bus.rptr !== e.rptr) begin n_err++; $display("FAIL uf_rptr[%0d] got %b want %b", k, bus.rptr, e.rptr); end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    pulse_reset();
    bus.rq2_wptr = gray5(5'd12);
    step(1'b0, 1'b0);
    void'(sb.pop_front());
    for (int k = 0; k < 7; k++) begin
      step(1'b1, 1'b0);
      e = sb.pop_front();
    end
    n_vec++; if (bus.rlevel !== e.lvl) begin n_err++; $display("FAIL mid_pre_lvl got %0d want %0d", bus.rlevel, e.lvl); end
    n_vec++; if (bus.raddr !== e.raddr) begin n_err++; $display("FAIL mid_pre_raddr got %0d want %0d", bus.raddr, e.raddr); end
    #2;
    rrst_n = 1'b0;
    #1;
    n_vec++; if (bus.rempty !== 1'b1) begin n_err++; $display("FAIL mid_rempty got %b want 1", bus.rempty); end
    n_vec++; if (bus.ralmost_empty !== 1'b1) begin n_err++; $display("FAIL mid_ae got %b want 1", bus.ralmost_empty); end
    n_vec++; if (bus.rlevel !== 5'd0) begin n_err++; $display("FAIL mid_lvl got %0d want 0", bus.rlevel); end
    n_vec++; if (bus.rptr !== 5'd0) begin n_err++; $display("FAIL mid_rptr got %b want 0", bus.rptr); end
    n_vec++; if (bus.raddr !== 4'd0) begin n_err++; $display("FAIL mid_raddr got %0d want 0", bus.raddr); end
    bus.rq2_wptr = gray5(5'd5);
    @(negedge rclk);
    rrst_n = 1'b1;
    model_reset();
    step(1'b0, 1'b0);
    e = sb.pop_front();
    n_vec++; if (bus.rempty !== e.rempty) begin n_err++; $display("FAIL post_rempty got %b want %b", bus.rempty, e.rempty); end
    n_vec++; if (bus.rlevel !== e.lvl) begin n_err++; $display("FAIL post_lvl got %0d want %0d", bus.rlevel, e.lvl); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full();
    test_underflow();
    test_reset_mid();
    n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL sb_leftover got %0d want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rptr_empty_lvl.md
Name: rptr_empty_lvl

Overview:
- Read-side pointer and status block for the dual-clock gray-pointer async FIFO, in the rclk domain.
- Keeps the binary and gray read pointers and drives the RAM read address.
- Produces registered empty from the synchronised write pointer.
- Adds fill-level reporting, a programmable almost-empty flag and a sticky underflow error with clear.

Parameters:
- ADDRSIZE, 4: RAM address width. Depth = 2^ADDRSIZE. Pointers are ADDRSIZE+1 bits.
- LVL_REG, 1: 1 = rlevel and ralmost_empty registered (one rclk latency); 0 = combinational from the current pointers.

Ports:
- rclk  input  1  read clock
- rrst_n  input  1  asynchronous active-low reset
- rinc  input  1  read request; honoured only when rempty=0
- rq2_wptr  input  ADDRSIZE+1  write gray pointer, already 2-flop synchronised into rclk
- ae_thresh  input  ADDRSIZE+1  almost-empty threshold; quasi-static
- runderflow_clr  input  1  pulse clears the sticky underflow flag
- raddr  output  ADDRSIZE  RAM read address = rbin[ADDRSIZE-1:0]
- rptr  output  ADDRSIZE+1  registered gray read pointer, sent to the write-domain synchroniser
- rempty  output  1  FIFO empty, registered
- ralmost_empty  output  1  level <= ae_thresh
- rlevel  output  ADDRSIZE+1  entries available, 0..2^ADDRSIZE
- runderflow  output  1  sticky: a read was attempted while empty

Behaviour:
- Reset is rrst_n, asynchronous, active-low; clock is rclk. Assertion acts immediately, without a clock edge.
- Reset values: rbin=0, rptr=0, raddr=0, rempty=1, ralmost_empty=1, rlevel=0, runderflow=0.
- rbinnext = rbin + (rinc & ~rempty), modulo 2^(ADDRSIZE+1).
- rgraynext = (rbinnext >> 1) ^ rbinnext.
- {rbin, rptr} <= {rbinnext, rgraynext} on every rclk edge.
- rempty <= (rgraynext == rq2_wptr). Empty therefore deasserts one rclk after a new rq2_wptr arrives, and asserts in the same cycle the last entry is read.
- wbin = gray2bin(rq2_wptr), combinational: bit i = XOR of bits ADDRSIZE..i.
- lvl_next = wbin - rbinnext, modulo 2^(ADDRSIZE+1).
- LVL_REG=1: rlevel <= lvl_next and ralmost_empty <= (lvl_next <= ae_thresh), unsigned compare.
- LVL_REG=0: rlevel = wbin - rbin and ralmost_empty is computed from it combinationally.
- Invariant: rempty=1 implies rlevel=0 (LVL_REG=1).
- Underflow: rinc=1 while rempty=1 leaves the pointers unchanged and sets runderflow on the next edge.
  - runderflow_clr=1 clears it.
  - Simultaneous set and clear: set wins.
- Wrap-around: rbin goes from 2^(ADDRSIZE+1)-1 to 0, raddr from 2^ADDRSIZE-1 to 0.
  - The gray pointer changes exactly one bit per increment, including across the wrap.
- Full FIFO: rq2_wptr differs from rptr in the top two gray bits only; rlevel = 2^ADDRSIZE.
- rlevel > 2^ADDRSIZE is illegal; the bench asserts against it. No saturation logic.
- rq2_wptr is trusted to change by single gray steps. Multi-step jumps are allowed (slow rclk) because gray2bin is exact.
- ae_thresh is sampled every cycle. A threshold change takes effect on the next edge.

Decomposition:
- Shared package fifo_pkg:
  - functions bin2gray and gray2bin, parametrised on width;
  - localparams PTRW = ADDRSIZE+1 and DEPTH = 2^ADDRSIZE.
  - The matching write-side block reuses the same package.
- One combinational sub-module, gray2bin_conv (parameter W), instantiated for rq2_wptr.
- Pointer register, empty register, level logic and underflow flag all stay in the top module.

Test Plan (ADDRSIZE=4, LVL_REG=1, ae_thresh=2 unless stated):
- Reset, with rq2_wptr=0 -> rempty=1, ralmost_empty=1, rlevel=0, rptr=0, raddr=0, runderflow=0.
- Drive rq2_wptr=5'b00010 (bin 3) -> next edge rempty=0, rlevel=3, ralmost_empty=0.
  - Then rinc=1 for 3 cycles -> raddr 0,1,2 then 3; rlevel 2,1,0; ralmost_empty=1 after the first read; rempty=1 after the third; runderflow stays 0.
- Wrap test: stream 40 reads, with rq2_wptr always one gray step ahead of rptr.
  - rptr Hamming distance is 1 per increment; rbin 31->0 and raddr 15->0 are correct.
  - rempty is never spuriously 1 across the wrap.
- Full level: rbin=0 and rq2_wptr=5'b11000 (bin 16) -> rlevel=16, rempty=0, ralmost_empty=0.
  - With ae_thresh=16 -> ralmost_empty=1 next edge.
- Underflow: rempty=1, rinc=1 for 1 cycle -> rptr unchanged, runderflow=1 and held.
  - runderflow_clr together with another rinc -> runderflow stays 1.
  - runderflow_clr alone -> runderflow=0.
- Reset mid-operation: with rbin=7 and rlevel=5, assert rrst_n low between clock edges.
  - All outputs go to reset values immediately.
  - After release with rq2_wptr=gray(5), the first edge gives rempty=0 and rlevel=5.
